branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and redirect controller for the RV32I 5-stage pipeline. A direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry serves IF-stage predictions. It is trained by EX-stage branch resolution. It also raises the mispredict redirect and flush request, and keeps branch/miss statistics counters.

## Interface
- `IDX_W`, 6: BTB index width; ENTRIES = 2^IDX_W. Index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2].
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_pc`  in  32  PC being fetched.
- `pred_taken`  out  1  IF prediction: taken.
- `pred_target`  out  32  IF predicted next PC: target if pred_taken, else if_pc+4.
- `ex_valid`  in  1  EX holds a valid conditional branch (br_type != NOBRANCH, not bubbled/stalled).
- `ex_pc`  in  32  PC of the EX branch.
- `ex_br`  in  1  actual outcome from branch decision logic.
- `ex_target`  in  32  actual taken target computed in EX.
- `ex_pred_taken`  in  1  pred_taken piped from IF with this branch.
- `ex_pred_target`  in  32  pred_target piped from IF with this branch.
- `mispredict`  out  1  redirect + flush IF/ID request, this cycle.
- `redirect_pc`  out  32  correct next PC: ex_br ? ex_target : ex_pc+4.
- `br_total`, `br_miss`  out  32 each  statistics counters.

## Operation
- Entry state: valid, tag, target[31:0], ctr[1:0] (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Lookup (combinational on `if_pc`):
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? entry.target : if_pc+4.
- Mispredict (combinational, gated by ex_valid):
  - ex_br=1: asserted when ex_pred_taken=0, or when ex_pred_target != ex_target.
  - ex_br=0: asserted when ex_pred_taken=1.
  - Always 0 when ex_valid=0.
- Update on rising clk when ex_valid=1, entry indexed by ex_pc:
  - Hit: ctr saturating +1 if ex_br, −1 if not. Target rewritten with ex_target if ex_br.
  - Miss and ex_br=1: allocate and overwrite any prior entry. Set valid=1, tag, target=ex_target, ctr=10.
  - Miss and ex_br=0: no change.
- Statistics (when ex_valid=1):
  - br_total increments every valid branch.
  - br_miss increments when mispredict=1.
  - Both wrap modulo 2^32.

## Timing
- Lookup and mispredict/redirect_pc are zero-latency combinational. The pipeline flushes IF/ID and loads redirect_pc into PC on the same edge.
- Table and counter updates become visible to lookup on the cycle after the update edge.
- Same-cycle update and lookup of the same index: lookup returns the pre-update contents.
- Counter saturation:
  - 11 + taken stays 11.
  - 00 + not-taken stays 00.
- Reset (asynchronous assert, any cycle including mid-update):
  - All valid=0, all ctr=01.
  - br_total=0, br_miss=0.
  - Consequently pred_taken=0 and pred_target=if_pc+4 immediately.
  - An update edge coinciding with reset is discarded.
- Aliasing: a tag mismatch on update with ex_br=1 replaces the entry. No partial-tag hit is permitted.
- ex_valid held 0 (stall/bubble): no state change and no counter increment, regardless of other EX inputs.

## Test plan
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104, br_total=br_miss=0.
- Taken branch ex_pc=0x100, ex_target=0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80, br_miss=1. Next cycle if_pc=0x100 gives pred_taken=1, pred_target=0x80.
- Same branch resolved not-taken three times → ctr goes 10→01→00→00. Lookup pred_taken=0 after the first. The first resolution gives mispredict=1 with redirect_pc=0x104; the later two give mispredict=0.
- Alias (IDX_W=6): ex_pc=0x100 and ex_pc=0x200 both taken, alternating → each replaces the other. Lookup of 0x100 after 0x200 is written returns a miss (pred_taken=0).
- Predicted taken with the wrong target (ex_pred_target=0x80, ex_target=0x90, ex_br=1) → mispredict=1, redirect_pc=0x90, entry target updated to 0x90.
- rst_n pulsed low mid-run with ex_valid=1 on that edge → no update; all counters 0; every lookup a miss.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, EX-stage training, redirect and statistics
module branch_predictor #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_br,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_total,
    output logic [31:0] br_miss
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic             valid  [ENTRIES];
    logic [1:0]       ctr    [ENTRIES];
    logic [TAG_W-1:0] tag    [ENTRIES];
    logic [31:0]      target [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             ex_hit;
    logic [1:0]       ex_ctr, ctr_nxt;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // IF lookup and EX resolution are both purely combinational; state only changes on the edge
    always_comb begin
        pred_taken  = valid[if_idx] && tag[if_idx] == if_tag && ctr[if_idx][1];
        pred_target = pred_taken ? target[if_idx] : if_pc + 32'd4;
        mispredict  = ex_valid && (ex_br ? (!ex_pred_taken || ex_pred_target != ex_target) : ex_pred_taken);
        redirect_pc = ex_br ? ex_target : ex_pc + 32'd4;
        ex_hit      = valid[ex_idx] && tag[ex_idx] == ex_tag;
        ex_ctr      = ctr[ex_idx];
        ctr_nxt     = ex_br ? (&ex_ctr ? ex_ctr : ex_ctr + 2'd1) : (|ex_ctr ? ex_ctr - 2'd1 : ex_ctr);
    end

    // Valid bits, counters and statistics: async reset wipes predictions and stats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= 2'b01;
            end
            br_total <= '0;
            br_miss  <= '0;
        end else if (ex_valid) begin
            br_total <= br_total + 32'd1;
            if (mispredict) br_miss <= br_miss + 32'd1;
            if (ex_hit) ctr[ex_idx] <= ctr_nxt;
            else if (ex_br) begin
                valid[ex_idx] <= 1'b1;
                ctr[ex_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target payload needs no reset since valid gates every use; an edge under reset is still dropped
    always_ff @(posedge clk) begin
        if (rst_n && ex_valid && ex_br) begin
            tag[ex_idx]    <= ex_tag;
            target[ex_idx] <= ex_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed stimulus, per-cycle comparison against a table model plus literal checks
module tb_branch_predictor;
    logic        clk = 0, rst_n = 0;
    logic [31:0] if_pc = 0, ex_pc = 0, ex_target = 0, ex_pred_target = 0;
    logic        ex_valid = 0, ex_br = 0, ex_pred_taken = 0;
    logic        pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc, br_total, br_miss;
    int          checks = 0, errors = 0;
    bit          on = 0;

    bit          m_v   [64];
    int unsigned m_tag [64];
    int unsigned m_tgt [64];
    int          m_ctr [64];
    int unsigned m_total, m_miss;

    branch_predictor #(.IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br(ex_br), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .br_total(br_total), .br_miss(br_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_mis();
        if (!ex_valid) return 0;
        return ex_br ? (!ex_pred_taken || ex_pred_target != ex_target) : ex_pred_taken;
    endfunction

    function automatic bit m_taken(input int unsigned pc);
        int i = (pc / 4) % 64;
        return m_v[i] && m_tag[i] == pc / 256 && m_ctr[i] >= 2;
    endfunction

    // Reference table: one slot per index, counter kept as an integer 0..3
    always @(posedge clk or negedge rst_n) begin
        int i;
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) begin
                m_v[k] = 0;
                m_ctr[k] = 1;
            end
            m_total = 0;
            m_miss = 0;
        end else if (ex_valid) begin
            m_total++;
            if (m_mis()) m_miss++;
            i = (ex_pc / 4) % 64;
            if (m_v[i] && m_tag[i] == ex_pc / 256) begin
                m_ctr[i] = ex_br ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
                if (ex_br) m_tgt[i] = ex_target;
            end else if (ex_br) begin
                m_v[i] = 1;
                m_tag[i] = ex_pc / 256;
                m_tgt[i] = ex_target;
                m_ctr[i] = 2;
            end
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        if (on) begin
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_taken(if_pc)});
            chk("pred_target", pred_target, m_taken(if_pc) ? m_tgt[(if_pc / 4) % 64] : if_pc + 32'd4);
            chk("mispredict", {31'd0, mispredict}, {31'd0, m_mis()});
            if (ex_valid) chk("redirect_pc", redirect_pc, ex_br ? ex_target : ex_pc + 32'd4);
            chk("br_total", br_total, m_total);
            chk("br_miss", br_miss, m_miss);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic v, input logic [31:0] pc, input logic br, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptgt);
        ex_valid = v; ex_pc = pc; ex_br = br; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    initial begin
        cyc();
        on = 1;
        cyc();
        rst_n = 1;
        if_pc = 32'h100;
        #3;
        chk("lit_reset_pt", {31'd0, pred_taken}, 0);
        chk("lit_reset_ptgt", pred_target, 32'h104);
        chk("lit_reset_tot", br_total, 0);
        chk("lit_reset_miss", br_miss, 0);
        cyc();
        ex(1, 32'h100, 1, 32'h80, 0, 32'h104);
        #3;
        chk("lit_alloc_mis", {31'd0, mispredict}, 1);
        chk("lit_alloc_redir", redirect_pc, 32'h80);
        cyc();
        ex(0, 0, 0, 0, 0, 0);
        #3;
        chk("lit_hit_pt", {31'd0, pred_taken}, 1);
        chk("lit_hit_ptgt", pred_target, 32'h80);
        chk("lit_miss1", br_miss, 1);
        cyc();
        ex(1, 32'h100, 0, 32'h80, 1, 32'h80);
        #3;
        chk("lit_nt1_mis", {31'd0, mispredict}, 1);
        chk("lit_nt1_redir", redirect_pc, 32'h104);
        cyc();
        ex(1, 32'h100, 0, 32'h80, 0, 32'h104);
        #3;
        chk("lit_nt2_pt", {31'd0, pred_taken}, 0);
        chk("lit_nt2_mis", {31'd0, mispredict}, 0);
        cyc();
        #3;
        chk("lit_nt3_mis", {31'd0, mispredict}, 0);
        cyc();
        ex(0, 0, 0, 0, 0, 0);
        #3;
        chk("lit_tot4", br_total, 4);
        chk("lit_miss2", br_miss, 2);
        cyc();
        ex(1, 32'h200, 1, 32'h300, 0, 32'h204);
        cyc();
        ex(0, 0, 0, 0, 0, 0);
        #3;
        chk("lit_alias_miss", {31'd0, pred_taken}, 0);
        cyc();
        if_pc = 32'h200;
        #3;
        chk("lit_alias_hit", pred_target, 32'h300);
        cyc();
        ex(1, 32'h100, 1, 32'h80, 0, 32'h104);
        cyc();
        ex(0, 0, 0, 0, 0, 0);
        #3;
        chk("lit_alias_back", {31'd0, pred_taken}, 0);
        cyc();
        if_pc = 32'h100;
        ex(1, 32'h100, 1, 32'h90, 1, 32'h80);
        #3;
        chk("lit_wrongtgt_mis", {31'd0, mispredict}, 1);
        chk("lit_wrongtgt_redir", redirect_pc, 32'h90);
        cyc();
        ex(1, 32'h100, 1, 32'h90, 1, 32'h90);
        #3;
        chk("lit_newtgt", pred_target, 32'h90);
        chk("lit_ok_mis", {31'd0, mispredict}, 0);
        cyc();
        cyc();
        ex(1, 32'h100, 0, 32'h90, 1, 32'h90);
        cyc();
        ex(0, 0, 0, 0, 0, 0);
        #3;
        chk("lit_sat_pt", {31'd0, pred_taken}, 1);
        cyc();
        if_pc = 32'h104;
        ex(1, 32'h104, 1, 32'h500, 0, 32'h108);
        #3;
        chk("lit_same_cycle", {31'd0, pred_taken}, 0);
        cyc();
        ex(0, 32'h108, 1, 32'h600, 1, 32'h999);
        #3;
        chk("lit_after_upd", pred_target, 32'h500);
        chk("lit_stall_mis", {31'd0, mispredict}, 0);
        cyc();
        if_pc = 32'h108;
        #3;
        chk("lit_stall_noalloc", {31'd0, pred_taken}, 0);
        cyc();
        if_pc = 32'h100;
        ex(1, 32'h10C, 1, 32'h700, 0, 32'h110);
        rst_n = 0;
        #3;
        chk("lit_rst_pt", {31'd0, pred_taken}, 0);
        chk("lit_rst_tot", br_total, 0);
        cyc();
        rst_n = 1;
        ex(0, 0, 0, 0, 0, 0);
        foreach (m_v[k]) if (k < 4) begin
            if_pc = 32'h100 + 32'(k * 4);
            #3;
            chk("lit_post_rst_miss", {31'd0, pred_taken}, 0);
            cyc();
        end
        if_pc = 32'h10C;
        #3;
        chk("lit_post_rst_tot", br_total, 0);
        cyc();
        on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
